// File: rtl/rcv_fifo_pkg.sv
// rcv_fifo_pkg: shared sizing and pointer type for the 3-row receive FIFO
package rcv_fifo_pkg;
  localparam int RCV_DEPTH = 3;
  localparam int RCV_PTR_W = 2;
  localparam logic [RCV_PTR_W-1:0] RCV_ROLL_VAL = 2'b10;
  typedef logic [RCV_PTR_W-1:0] rcv_ptr_t;
endpackage

// File: rtl/fifo_flex_counter.sv
// fifo_flex_counter: 0..rollover_val counter that flips a wrap toggle each time it rolls over
module fifo_flex_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_out,
  output logic         wrap_tog
);
  // count up on enable; reaching rollover_val returns to 0 and flips the toggle in the same edge
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      count_out <= '0;
      wrap_tog  <= 1'b0;
    end else if (clear) begin
      count_out <= '0;
      wrap_tog  <= 1'b0;
    end else if (count_enable) begin
      count_out <= (count_out == rollover_val) ? '0 : count_out + 1'b1;
      wrap_tog  <= (count_out == rollover_val) ? ~wrap_tog : wrap_tog;
    end
endmodule

// File: rtl/rcv_counter_tail.sv
// rcv_counter_tail: tail index/toggle, a mirror of the head counter advanced by accepted writes
module rcv_counter_tail
  import rcv_fifo_pkg::*;
(
  input  logic     clk,
  input  logic     n_rst,
  input  logic     wr_en,
  output rcv_ptr_t tail_ptr,
  output logic     tail_tog
);
  fifo_flex_counter #(.W(RCV_PTR_W)) u_cnt (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (1'b0),
    .count_enable(wr_en),
    .rollover_val(RCV_ROLL_VAL),
    .count_out   (tail_ptr),
    .wrap_tog    (tail_tog)
  );
endmodule

// File: rtl/rcv_fifo_ctrl.sv
// rcv_fifo_ctrl: write side, row storage and status/error flags of the 3-row receive FIFO
module rcv_fifo_ctrl
  import rcv_fifo_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rcv_enq,
  input  logic [DATA_W-1:0] rcv_wdata,
  input  logic              rcv_deq_req,
  input  logic [1:0]        head_ptr,
  input  logic              head_tog,
  input  logic              clear_err,
  output logic              rcv_deq,
  output logic [DATA_W-1:0] rcv_rdata,
  output logic              rcv_full,
  output logic              rcv_empty,
  output logic [1:0]        rcv_count,
  output logic              overflow_err,
  output logic              underflow_err
);
  logic [DATA_W-1:0] rows [RCV_DEPTH];
  rcv_ptr_t tail_ptr;
  logic tail_tog;
  logic wr_en;
  rcv_counter_tail u_tail (
    .clk     (clk),
    .n_rst   (n_rst),
    .wr_en   (wr_en),
    .tail_ptr(tail_ptr),
    .tail_tog(tail_tog)
  );
  // status from registered tail vs. incoming head; a write into a full FIFO is only legal when the head row leaves this cycle
  always_comb begin
    rcv_empty = (tail_ptr == head_ptr) && (tail_tog == head_tog);
    rcv_full  = (tail_ptr == head_ptr) && (tail_tog != head_tog);
    rcv_count = (tail_tog == head_tog) ? tail_ptr - head_ptr : 2'd3 + tail_ptr - head_ptr;
    rcv_deq   = rcv_deq_req && !rcv_empty;
    wr_en     = rcv_enq && (!rcv_full || rcv_deq);
    rcv_rdata = (head_ptr == 2'd0) ? rows[0] :
                (head_ptr == 2'd1) ? rows[1] :
                (head_ptr == 2'd2) ? rows[2] : '0;
  end
  // row write at the tail on every accepted enqueue
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int i = 0; i < RCV_DEPTH; i++) rows[i] <= '0;
    end else begin
      for (int i = 0; i < RCV_DEPTH; i++)
        if (wr_en && tail_ptr == rcv_ptr_t'(i)) rows[i] <= rcv_wdata;
    end
  // sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (rcv_enq && rcv_full && !rcv_deq) || (overflow_err && !clear_err);
      underflow_err <= (rcv_deq_req && rcv_empty) || (underflow_err && !clear_err);
    end
endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// tb_rcv_fifo_ctrl: queue-model checking of the receive FIFO controller with directed and random traffic
module tb_rcv_fifo_ctrl;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic rcv_enq = 1'b0, rcv_deq_req = 1'b0, clear_err = 1'b0;
  logic [31:0] rcv_wdata = '0;
  logic [1:0] head_ptr;
  logic head_tog;
  logic rcv_deq, rcv_full, rcv_empty, overflow_err, underflow_err;
  logic [31:0] rcv_rdata;
  logic [1:0] rcv_count;
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  logic m_ovf, m_udf;
  logic m_deq, m_wr, m_full;

  rcv_fifo_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .rcv_enq(rcv_enq), .rcv_wdata(rcv_wdata),
    .rcv_deq_req(rcv_deq_req), .head_ptr(head_ptr), .head_tog(head_tog),
    .clear_err(clear_err), .rcv_deq(rcv_deq), .rcv_rdata(rcv_rdata),
    .rcv_full(rcv_full), .rcv_empty(rcv_empty), .rcv_count(rcv_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // stand-in for the external head index counter, advanced by rcv_deq
  always @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      head_ptr <= 2'd0;
      head_tog <= 1'b0;
    end else if (rcv_deq) begin
      head_ptr <= (head_ptr == 2'd2) ? 2'd0 : head_ptr + 2'd1;
      head_tog <= (head_ptr == 2'd2) ? ~head_tog : head_tog;
    end

  // behavioural model: a queue of at most three words plus two sticky flags
  always @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      m_full = (q.size() == 3);
      m_deq  = rcv_deq_req && q.size() > 0;
      m_wr   = rcv_enq && (!m_full || m_deq);
      m_ovf  = (rcv_enq && m_full && !m_deq) || (m_ovf && !clear_err);
      m_udf  = (rcv_deq_req && q.size() == 0) || (m_udf && !clear_err);
      if (m_deq) void'(q.pop_front());
      if (m_wr) q.push_back(rcv_wdata);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle comparison of all outputs against the queue model
  always @(negedge clk)
    if (n_rst) begin
      chk("deq", 32'(rcv_deq), 32'(rcv_deq_req && q.size() > 0));
      chk("full", 32'(rcv_full), 32'(q.size() == 3));
      chk("empty", 32'(rcv_empty), 32'(q.size() == 0));
      chk("count", 32'(rcv_count), 32'(q.size()));
      chk("ovf", 32'(overflow_err), 32'(m_ovf));
      chk("udf", 32'(underflow_err), 32'(m_udf));
      if (q.size() > 0) chk("rdata", rcv_rdata, q[0]);
    end

  always @(negedge clk) assert (head_ptr != 2'd3);

  task automatic step(input logic e, input logic [31:0] d, input logic r, input logic c);
    rcv_enq = e;
    rcv_wdata = d;
    rcv_deq_req = r;
    clear_err = c;
    @(posedge clk);
    #1;
    rcv_enq = 1'b0;
    rcv_deq_req = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    #12 n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_empty", 32'(rcv_empty), 32'd1);
    chk("rst_full", 32'(rcv_full), 32'd0);
    chk("rst_count", 32'(rcv_count), 32'd0);
    chk("rst_deq", 32'(rcv_deq), 32'd0);
    chk("rst_rdata", rcv_rdata, 32'd0);
    chk("rst_errs", 32'({overflow_err, underflow_err}), 32'd0);
    step(1'b1, 32'hA1, 1'b0, 1'b0);
    chk("cnt1", 32'(rcv_count), 32'd1);
    chk("rd_a1_1", rcv_rdata, 32'hA1);
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    chk("cnt2", 32'(rcv_count), 32'd2);
    step(1'b1, 32'hC3, 1'b0, 1'b0);
    chk("cnt3", 32'(rcv_count), 32'd3);
    chk("full3", 32'(rcv_full), 32'd1);
    chk("rd_a1_3", rcv_rdata, 32'hA1);
    chk("model_sz3", 32'(q.size()), 32'd3);
    step(1'b1, 32'hD4, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow_err), 32'd1);
    chk("ovf_cnt", 32'(rcv_count), 32'd3);
    chk("ovf_rd", rcv_rdata, 32'hA1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow_err), 32'd0);
    rcv_enq = 1'b1;
    rcv_wdata = 32'hE5;
    rcv_deq_req = 1'b1;
    #1;
    chk("full_deq", 32'(rcv_deq), 32'd1);
    step(1'b1, 32'hE5, 1'b1, 1'b0);
    chk("fd_cnt", 32'(rcv_count), 32'd3);
    chk("fd_ovf", 32'(overflow_err), 32'd0);
    chk("rd_b2", rcv_rdata, 32'hB2);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("rd_c3", rcv_rdata, 32'hC3);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("rd_e5", rcv_rdata, 32'hE5);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drained", 32'(rcv_empty), 32'd1);
    rcv_deq_req = 1'b1;
    #1;
    chk("udf_deq", 32'(rcv_deq), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("udf_set", 32'(underflow_err), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("udf_clr", 32'(underflow_err), 32'd0);
    rcv_enq = 1'b1;
    rcv_wdata = 32'hF6;
    rcv_deq_req = 1'b1;
    #1;
    chk("ed_deq", 32'(rcv_deq), 32'd0);
    step(1'b1, 32'hF6, 1'b1, 1'b0);
    chk("ed_cnt", 32'(rcv_count), 32'd1);
    chk("ed_rd", rcv_rdata, 32'hF6);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    chk("pairs_empty", 32'(rcv_empty), 32'd1);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b1);
    #3 n_rst = 1'b0;
    #1;
    chk("mrst_empty", 32'(rcv_empty), 32'd1);
    chk("mrst_full", 32'(rcv_full), 32'd0);
    chk("mrst_count", 32'(rcv_count), 32'd0);
    chk("mrst_rdata", rcv_rdata, 32'd0);
    chk("mrst_errs", 32'({overflow_err, underflow_err}), 32'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("post_empty", 32'(rcv_empty), 32'd1);
    chk("post_count", 32'(rcv_count), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
